// File: rtl/wb_stage_pkg.sv
// Shared constants for the write-back stage: bus widths, CP0 register
// addresses ({rd,sel}), exception codes and the memory-stage bus layout.
package wb_stage_pkg;

  localparam int MS_TO_WS_BUS_WD = 124;
  localparam int WS_TO_RF_BUS_WD = 41;

  localparam logic [7:0] CP0_BADVADDR = {5'd8,  3'd0};
  localparam logic [7:0] CP0_COUNT    = {5'd9,  3'd0};
  localparam logic [7:0] CP0_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0] CP0_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] CP0_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] CP0_EPC      = {5'd14, 3'd0};

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exccode_e;

  typedef struct packed {
    logic [4:0]  excode;
    logic [31:0] badvaddr;
    logic [7:0]  cp0_addr;
    logic        ex;
    logic        bd;
    logic        eret;
    logic        syscall;
    logic        mfc0;
    logic        mtc0;
    logic [3:0]  gr_strb;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } ms_to_ws_bus_t;

endpackage

// File: rtl/wb_stage_cp0.sv
// CP0 register file: BadVAddr, Count/Compare timer, Status, Cause, EPC,
// plus the interrupt-pending detect.
module cp0_regfile
  import wb_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        we_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic        ex_i,
  input  logic [4:0]  excode_i,
  input  logic        bd_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] badvaddr_i,
  input  logic        eret_i,
  input  logic [5:0]  ext_int_i,
  output logic [31:0] rdata_o,
  output logic [31:0] epc_o,
  output logic        int_pend_o
);

  logic        tick_q, tick_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  excode_q, excode_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;

  always_comb begin
    tick_d     = ~tick_q;
    count_d    = count_q;
    compare_d  = compare_q;
    ti_d       = ti_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_hw_d    = {ext_int_i[5] | ti_q, ext_int_i[4:0]};
    ip_sw_d    = ip_sw_q;
    excode_d   = excode_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;

    if (tick_q) count_d = count_q + 32'd1;
    if (count_q == compare_q) ti_d = 1'b1;

    // Software writes come after the timer so mtc0 overrides tick and TI set.
    if (we_i) begin
      unique case (addr_i)
        CP0_COUNT:   count_d = wdata_i;
        CP0_COMPARE: begin
          compare_d = wdata_i;
          ti_d      = 1'b0;
        end
        CP0_STATUS: begin
          im_d  = wdata_i[15:8];
          exl_d = wdata_i[1];
          ie_d  = wdata_i[0];
        end
        CP0_CAUSE:   ip_sw_d = wdata_i[9:8];
        CP0_EPC:     epc_d   = wdata_i;
        default: ;
      endcase
    end

    if (ex_i) begin
      exl_d    = 1'b1;
      excode_d = excode_i;
      if (!exl_q) begin
        bd_d  = bd_i;
        epc_d = bd_i ? pc_i - 32'd4 : pc_i;
      end
      if (excode_i == EXC_ADEL || excode_i == EXC_ADES) badvaddr_d = badvaddr_i;
    end else if (eret_i) begin
      exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tick_q     <= 1'b0;
      count_q    <= '0;
      compare_q  <= '0;
      ti_q       <= 1'b0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_hw_q    <= '0;
      ip_sw_q    <= '0;
      excode_q   <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else begin
      tick_q     <= tick_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      ti_q       <= ti_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      excode_q   <= excode_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    unique case (addr_i)
      CP0_BADVADDR: rdata_o = badvaddr_q;
      CP0_COUNT:    rdata_o = count_q;
      CP0_COMPARE:  rdata_o = compare_q;
      CP0_STATUS:   rdata_o = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
      CP0_CAUSE:    rdata_o = {bd_q, ti_q, 14'b0, ip_hw_q, ip_sw_q, 1'b0, excode_q, 2'b0};
      CP0_EPC:      rdata_o = epc_q;
      default:      rdata_o = '0;
    endcase
  end

  assign epc_o      = epc_q;
  assign int_pend_o = ie_q & ~exl_q & (|({ip_hw_q, ip_sw_q} & im_q));

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: holds the retiring instruction, commits register and CP0
// effects, raises exception/eret redirects and drives the trace port.
module wb_stage #(
  parameter int          MS_TO_WS_BUS_WD = wb_stage_pkg::MS_TO_WS_BUS_WD,
  parameter int          WS_TO_RF_BUS_WD = wb_stage_pkg::WS_TO_RF_BUS_WD,
  parameter logic [31:0] EX_ENTRY        = 32'hbfc00380
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       ws_allowin,
  input  logic                       ms_to_ws_valid,
  input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic [5:0]                 ext_int_in,
  output logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus,
  output logic                       ws_ex,
  output logic                       ws_eret,
  output logic [31:0]                ws_new_pc,
  output logic                       ws_inst_mtc0_o,
  output logic [31:0]                debug_wb_pc,
  output logic [3:0]                 debug_wb_rf_wen,
  output logic [4:0]                 debug_wb_rf_wnum,
  output logic [31:0]                debug_wb_rf_wdata
);
  import wb_stage_pkg::*;

  logic                       ws_valid_q;
  logic [MS_TO_WS_BUS_WD-1:0] bus_q;
  ms_to_ws_bus_t              ws_bus;

  logic        int_pend;
  logic [31:0] cp0_rdata;
  logic [31:0] cp0_epc;
  logic [4:0]  excode_eff;
  logic        cp0_we;
  logic [3:0]  rf_we;
  logic [31:0] rf_wdata;
  logic        unused_syscall;

  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid_q <= 1'b0;
      bus_q      <= '0;
    end else begin
      ws_valid_q <= ms_to_ws_valid;
      if (ms_to_ws_valid) bus_q <= ms_to_ws_bus;
    end
  end

  assign ws_bus         = ms_to_ws_bus_t'(bus_q);
  assign unused_syscall = ws_bus.syscall;
  assign ws_allowin     = 1'b1;

  // A pending interrupt hijacks whatever instruction is in WB.
  assign excode_eff = int_pend ? EXC_INT : ws_bus.excode;
  assign ws_ex      = ws_valid_q & (ws_bus.ex | int_pend);
  assign ws_eret    = ws_valid_q & ws_bus.eret & ~ws_ex;
  assign cp0_we     = ws_valid_q & ws_bus.mtc0 & ~ws_ex;
  assign ws_new_pc  = ws_eret ? cp0_epc : EX_ENTRY;

  assign ws_inst_mtc0_o = ws_valid_q & ws_bus.mtc0;

  assign rf_we        = {4{ws_valid_q & ~ws_ex}} & ws_bus.gr_strb;
  assign rf_wdata     = ws_bus.mfc0 ? cp0_rdata : ws_bus.result;
  assign ws_to_rf_bus = {rf_we, ws_bus.dest, rf_wdata};

  assign debug_wb_pc       = ws_bus.pc;
  assign debug_wb_rf_wen   = rf_we;
  assign debug_wb_rf_wnum  = ws_bus.dest;
  assign debug_wb_rf_wdata = rf_wdata;

  cp0_regfile u_cp0 (
    .clk_i      (clk),
    .reset_i    (reset),
    .we_i       (cp0_we),
    .addr_i     (ws_bus.cp0_addr),
    .wdata_i    (ws_bus.result),
    .ex_i       (ws_ex),
    .excode_i   (excode_eff),
    .bd_i       (ws_bus.bd),
    .pc_i       (ws_bus.pc),
    .badvaddr_i (ws_bus.badvaddr),
    .eret_i     (ws_eret),
    .ext_int_i  (ext_int_in),
    .rdata_o    (cp0_rdata),
    .epc_o      (cp0_epc),
    .int_pend_o (int_pend)
  );

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed commit/CP0 scenarios followed by random
// traffic, all compared against an architectural CP0 model.
module tb_wb_stage;

  localparam logic [31:0] EXV      = 32'hbfc00380;
  localparam logic [7:0]  A_BADV   = 8'h40;
  localparam logic [7:0]  A_COUNT  = 8'h48;
  localparam logic [7:0]  A_CMP    = 8'h58;
  localparam logic [7:0]  A_STATUS = 8'h60;
  localparam logic [7:0]  A_CAUSE  = 8'h68;
  localparam logic [7:0]  A_EPC    = 8'h70;
  localparam logic [5:0]  F_EX = 6'b100000, F_BD = 6'b010000, F_ERET = 6'b001000;
  localparam logic [5:0]  F_SYS = 6'b000100, F_MFC0 = 6'b000010, F_MTC0 = 6'b000001;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ws_allowin;
  logic         ms_to_ws_valid = 1'b0;
  logic [123:0] ms_to_ws_bus = '0;
  logic [5:0]   ext_int_in = '0;
  logic [40:0]  ws_to_rf_bus;
  logic         ws_ex, ws_eret, ws_inst_mtc0_o;
  logic [31:0]  ws_new_pc, debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]   debug_wb_rf_wen;
  logic [4:0]   debug_wb_rf_wnum;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  wb_stage #(
    .MS_TO_WS_BUS_WD(124),
    .WS_TO_RF_BUS_WD(41),
    .EX_ENTRY       (32'hbfc00380)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .ws_allowin       (ws_allowin),
    .ms_to_ws_valid   (ms_to_ws_valid),
    .ms_to_ws_bus     (ms_to_ws_bus),
    .ext_int_in       (ext_int_in),
    .ws_to_rf_bus     (ws_to_rf_bus),
    .ws_ex            (ws_ex),
    .ws_eret          (ws_eret),
    .ws_new_pc        (ws_new_pc),
    .ws_inst_mtc0_o   (ws_inst_mtc0_o),
    .debug_wb_pc      (debug_wb_pc),
    .debug_wb_rf_wen  (debug_wb_rf_wen),
    .debug_wb_rf_wnum (debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Architectural CP0 state plus the instruction currently held in WB.
  typedef struct {
    logic [31:0] count, compare, epc, badv;
    logic        tick, ti, exl, ie, bd;
    logic [7:0]  im;
    logic [5:0]  ip_hw;
    logic [1:0]  ip_sw;
    logic [4:0]  code;
  } cp0_t;

  cp0_t         m;
  logic         h_valid = 1'b0;
  logic [123:0] h_bus = '0;

  function automatic logic m_int();
    return m.ie && !m.exl && (({m.ip_hw, m.ip_sw} & m.im) != 8'h00);
  endfunction

  function automatic logic m_ex();
    return h_valid && (h_bus[78] || m_int());
  endfunction

  function automatic logic m_eret();
    return h_valid && h_bus[76] && !m_ex();
  endfunction

  function automatic logic [31:0] m_rd(input logic [7:0] a);
    case (a)
      A_BADV:   return m.badv;
      A_COUNT:  return m.count;
      A_CMP:    return m.compare;
      A_STATUS: return 32'h00400000 | {16'h0, m.im, 6'b0, m.exl, m.ie};
      A_CAUSE:  return {m.bd, m.ti, 14'b0, m.ip_hw, m.ip_sw, 1'b0, m.code, 2'b0};
      A_EPC:    return m.epc;
      default:  return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m = '{default: '0};
    h_valid = 1'b0;
    h_bus = '0;
  endtask

  // Effects of the clock edge that retires the held instruction.
  task automatic model_edge(input logic [5:0] ext);
    cp0_t        n;
    logic        ex, wr;
    logic [4:0]  code;
    logic [7:0]  a;
    logic [31:0] d, pc;
    n    = m;
    ex   = m_ex();
    code = m_int() ? 5'd0 : h_bus[123:119];
    wr   = h_valid && h_bus[73] && !ex;
    a    = h_bus[86:79];
    d    = h_bus[63:32];
    pc   = h_bus[31:0];
    n.tick  = !m.tick;
    n.count = m.tick ? m.count + 1 : m.count;
    if (m.count == m.compare) n.ti = 1'b1;
    n.ip_hw = {ext[5] | m.ti, ext[4:0]};
    if (wr) begin
      if (a == A_COUNT)  n.count = d;
      if (a == A_CMP)    begin n.compare = d; n.ti = 1'b0; end
      if (a == A_STATUS) begin n.im = d[15:8]; n.exl = d[1]; n.ie = d[0]; end
      if (a == A_CAUSE)  n.ip_sw = d[9:8];
      if (a == A_EPC)    n.epc = d;
    end
    if (ex) begin
      n.exl  = 1'b1;
      n.code = code;
      if (!m.exl) begin
        n.bd  = h_bus[77];
        n.epc = h_bus[77] ? pc - 4 : pc;
      end
      if (code == 5'd4 || code == 5'd5) n.badv = h_bus[118:87];
    end else if (m_eret()) begin
      n.exl = 1'b0;
    end
    m = n;
  endtask

  task automatic check_outputs();
    logic        ex, er;
    logic [3:0]  we;
    logic [31:0] wd;
    ex = m_ex();
    er = m_eret();
    we = (h_valid && !ex) ? h_bus[72:69] : 4'h0;
    wd = h_bus[74] ? m_rd(h_bus[86:79]) : h_bus[63:32];
    chk("allowin", ws_allowin, 1);
    chk("ws_ex", ws_ex, ex);
    chk("ws_eret", ws_eret, er);
    chk("new_pc", ws_new_pc, er ? m.epc : EXV);
    chk("rf_bus", ws_to_rf_bus, {we, h_bus[68:64], wd});
    chk("dbg_pc", debug_wb_pc, h_bus[31:0]);
    chk("dbg_wen", debug_wb_rf_wen, we);
    chk("dbg_wnum", debug_wb_rf_wnum, h_bus[68:64]);
    chk("dbg_wdata", debug_wb_rf_wdata, wd);
    chk("mtc0_o", ws_inst_mtc0_o, h_valid && h_bus[73]);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic drive(input logic v, input logic [123:0] b, input logic [5:0] e,
                       input logic r = 1'b0);
    logic vv;
    vv = v && !(m_ex() || m_eret());
    if (r) begin
      model_reset();
      vv = 1'b0;
    end else begin
      model_edge(e);
      h_valid = vv;
      if (vv) h_bus = b;
    end
    reset = r;
    ms_to_ws_valid = vv;
    ms_to_ws_bus = b;
    ext_int_in = e;
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  function automatic logic [123:0] mk(input logic [4:0] code, input logic [31:0] badv,
      input logic [7:0] addr, input logic [5:0] flags, input logic [3:0] strb,
      input logic [4:0] dest, input logic [31:0] res, input logic [31:0] pc);
    return {code, badv, addr, flags, strb, dest, res, pc};
  endfunction

  function automatic logic [123:0] op_mtc0(input logic [7:0] a, input logic [31:0] d);
    return mk(5'd0, 32'h0, a, F_MTC0, 4'h0, 5'd0, d, 32'hbfc00010);
  endfunction

  function automatic logic [123:0] op_mfc0(input logic [7:0] a);
    return mk(5'd0, 32'h0, a, F_MFC0, 4'hf, 5'd2, 32'h0, 32'hbfc00020);
  endfunction

  task automatic bubble();
    drive(1'b0, '0, 6'h0);
  endtask

  logic [7:0] addrs [7] = '{8'h40, 8'h48, 8'h58, 8'h60, 8'h68, 8'h70, 8'h08};
  logic [4:0] codes [6] = '{5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        seen;
    logic [7:0]  a;
    logic [31:0] d;
    int unsigned k;
    model_reset();
    drive(1'b0, '0, 6'h0, 1'b1);
    drive(1'b0, '0, 6'h0, 1'b1);
    chk("rst_new_pc", ws_new_pc, EXV);
    chk("rst_rf_bus", ws_to_rf_bus, 0);
    chk("rst_dbg_pc", debug_wb_pc, 0);

    drive(1'b1, op_mtc0(A_CMP, 32'hffffffff), 6'h0);
    bubble();
    bubble();
    drive(1'b1, mk(5'd0, 32'h0, 8'h0, 6'h0, 4'hf, 5'd5, 32'h12345678, 32'hbfc00000), 6'h0);
    chk("add_wen", debug_wb_rf_wen, 4'hf);
    chk("add_wnum", debug_wb_rf_wnum, 5);
    chk("add_wdata", debug_wb_rf_wdata, 32'h12345678);
    chk("add_pc", debug_wb_pc, 32'hbfc00000);

    drive(1'b1, op_mtc0(A_STATUS, 32'h0000ff01), 6'h0);
    drive(1'b1, op_mfc0(A_STATUS), 6'h0);
    chk("mfc0_status", debug_wb_rf_wdata, 32'h0040ff01);
    drive(1'b1, op_mtc0(A_STATUS, 32'h0), 6'h0);

    drive(1'b1, mk(5'd8, 32'h0, 8'h0, F_EX | F_BD | F_SYS, 4'hf, 5'd3, 32'h0, 32'hbfc00100), 6'h0);
    chk("sys_ex", ws_ex, 1);
    chk("sys_wen", debug_wb_rf_wen, 0);
    chk("sys_new_pc", ws_new_pc, EXV);
    bubble();
    drive(1'b1, op_mfc0(A_EPC), 6'h0);
    chk("sys_epc", debug_wb_rf_wdata, 32'hbfc000fc);
    drive(1'b1, op_mfc0(A_CAUSE), 6'h0);
    chk("sys_cause", debug_wb_rf_wdata, 32'h80000020);
    drive(1'b1, op_mfc0(A_STATUS), 6'h0);
    chk("sys_exl", debug_wb_rf_wdata, 32'h00400002);

    drive(1'b1, mk(5'd4, 32'h3, 8'h0, F_EX, 4'h0, 5'd0, 32'h0, 32'hbfc00200), 6'h0);
    bubble();
    drive(1'b1, op_mfc0(A_BADV), 6'h0);
    chk("adel_badv", debug_wb_rf_wdata, 3);
    drive(1'b1, op_mfc0(A_EPC), 6'h0);
    chk("nested_epc", debug_wb_rf_wdata, 32'hbfc000fc);

    drive(1'b1, mk(5'd0, 32'h0, 8'h0, F_ERET, 4'h0, 5'd0, 32'h0, 32'hbfc00300), 6'h0);
    chk("eret", ws_eret, 1);
    chk("eret_pc", ws_new_pc, 32'hbfc000fc);
    bubble();
    drive(1'b1, op_mfc0(A_STATUS), 6'h0);
    chk("eret_exl", debug_wb_rf_wdata, 32'h00400000);

    drive(1'b1, op_mtc0(A_COUNT, 32'hffffffff), 6'h0);
    for (int i = 0; i < 4; i++) drive(1'b1, op_mfc0(A_COUNT), 6'h0);

    drive(1'b1, op_mtc0(A_COUNT, 32'h0), 6'h0);
    drive(1'b1, op_mtc0(A_CMP, 32'd10), 6'h0);
    bubble();
    drive(1'b1, op_mtc0(A_STATUS, 32'h00008001), 6'h0);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      drive(1'b1, mk(5'd0, 32'h0, 8'h0, 6'h0, 4'h0, 5'd0, 32'h0, 32'hbfc00400), 6'h0);
      if (ws_ex) begin
        seen = 1'b1;
        break;
      end
    end
    chk("timer_int_seen", seen, 1);
    bubble();
    drive(1'b1, op_mfc0(A_CAUSE), 6'h0);
    chk("int_code", debug_wb_rf_wdata[6:2], 0);
    chk("int_ti", debug_wb_rf_wdata[30], 1);
    drive(1'b1, op_mtc0(A_CMP, 32'd1000), 6'h0);
    drive(1'b1, op_mfc0(A_CAUSE), 6'h0);
    chk("ti_clear", debug_wb_rf_wdata[30], 0);
    drive(1'b1, op_mtc0(A_STATUS, 32'h0), 6'h0);

    for (int i = 0; i < 1500; i++) begin
      logic [5:0] ext;
      ext = ($urandom_range(0, 9) == 0) ? 6'($urandom()) : 6'h0;
      k = $urandom_range(0, 99);
      if (i == 700) begin
        drive(1'b0, '0, 6'h0, 1'b1);
        chk("mid_rst_new_pc", ws_new_pc, EXV);
      end else if (k < 40) begin
        drive(1'b1, mk(5'd0, 32'h0, 8'h0, 6'h0, 4'($urandom()), 5'($urandom()),
                       $urandom(), $urandom() & 32'hfffffffc), ext);
      end else if (k < 55) begin
        a = addrs[$urandom_range(0, 6)];
        drive(1'b1, mk(5'd0, 32'h0, a, F_MFC0, 4'($urandom()), 5'($urandom()),
                       $urandom(), 32'hbfc00500), ext);
      end else if (k < 75) begin
        a = addrs[$urandom_range(0, 6)];
        d = (a == A_COUNT || a == A_CMP) ? $urandom_range(0, 40) : $urandom();
        drive(1'b1, mk(5'd12, 32'h0, a, ($urandom_range(0, 7) == 0) ? (F_MTC0 | F_EX) : F_MTC0,
                       4'h0, 5'd0, d, $urandom() & 32'hfffffffc), ext);
      end else if (k < 88) begin
        drive(1'b1, mk(codes[$urandom_range(0, 5)], $urandom(), 8'h0,
                       ($urandom_range(0, 1) == 1) ? (F_EX | F_BD) : F_EX, 4'hf, 5'd7,
                       $urandom(), $urandom() & 32'hfffffffc), ext);
      end else if (k < 95) begin
        drive(1'b1, mk(5'd0, 32'h0, 8'h0, F_ERET, 4'h0, 5'd0, 32'h0, 32'hbfc00600), ext);
      end else begin
        drive(1'b0, '0, ext);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
